// File: rtl/seg_scan_8dig.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// One anode is lit per slot, with an optional all-off gap at the start of each slot.
module seg_scan_8dig #(
  parameter int REFRESH_DIV = 100_000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digits,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  en_mask,
  input  logic        blank_lz,
  output logic        CA,
  output logic        CB,
  output logic        CC,
  output logic        CD,
  output logic        CE,
  output logic        CF,
  output logic        CG,
  output logic        DP,
  output logic [7:0]  AN
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST    = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_P = PW'(BLANK_CYC);

  logic [PW-1:0] prescaler;
  logic [2:0]    idx;
  logic          tick;
  logic          in_gap;
  logic          blanked;
  logic          shown;
  logic [7:0]    zero_from;
  logic [3:0]    nibble;
  logic [7:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;
  logic [7:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;

  // Active-low {CA..CG} patterns for hex digits 0..F
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0:    seg_decode = 7'b0000001;
      4'h1:    seg_decode = 7'b1001111;
      4'h2:    seg_decode = 7'b0010010;
      4'h3:    seg_decode = 7'b0000110;
      4'h4:    seg_decode = 7'b1001100;
      4'h5:    seg_decode = 7'b0100100;
      4'h6:    seg_decode = 7'b0100000;
      4'h7:    seg_decode = 7'b0001111;
      4'h8:    seg_decode = 7'b0000000;
      4'h9:    seg_decode = 7'b0000100;
      4'hA:    seg_decode = 7'b0001000;
      4'hB:    seg_decode = 7'b1100000;
      4'hC:    seg_decode = 7'b0110001;
      4'hD:    seg_decode = 7'b1000010;
      4'hE:    seg_decode = 7'b0110000;
      default: seg_decode = 7'b0111000;
    endcase
  endfunction

  assign tick = (prescaler == LAST);

  // zero_from[i] is set when nibbles i..7 are all zero (leading-zero run)
  always_comb begin
    zero_from    = '0;
    zero_from[7] = (digits[31:28] == 4'h0);
    for (int i = 6; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (digits[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    nibble  = digits[{idx, 2'b00} +: 4];
    in_gap  = (prescaler < BLANK_P);
    blanked = blank_lz && (idx != 3'd0) && zero_from[idx];
    shown   = !in_gap && en_mask[idx] && !blanked;
    an_d    = 8'hFF;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    if (shown) begin
      an_d[idx] = 1'b0;
      seg_d     = seg_decode(nibble);
      dp_d      = ~dp_mask[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler <= '0;
      idx       <= 3'd0;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) idx <= idx + 3'd1;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;
  assign DP = dp_q;
  assign AN = an_q;

endmodule

// File: tb/tb_seg_scan_8dig.sv
// Scoreboard bench for seg_scan_8dig: a slot/position model predicts each edge's
// outputs, and a negedge monitor pops and compares them.
module tb_seg_scan_8dig;

  localparam int RDIV  = 4;
  localparam int BLANK = 1;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] digits;
  logic [7:0]  dp_mask;
  logic [7:0]  en_mask;
  logic        blank_lz;
  logic        CA, CB, CC, CD, CE, CF, CG, DP;
  logic [7:0]  AN;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   model_t  = 0;

  seg_scan_8dig #(.REFRESH_DIV(RDIV), .BLANK_CYC(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_mask(dp_mask),
    .en_mask(en_mask), .blank_lz(blank_lz),
    .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG),
    .DP(DP), .AN(AN)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
    end
  endtask

  // Drive one cycle's inputs and push what the upcoming edge must produce
  task automatic applyStimulus(input logic rst, input logic [31:0] dig, input logic [7:0] dpm,
                               input logic [7:0] enm, input logic lz);
    exp_t e;
    int   pos;
    int   slot;
    bit   lead_zero;
    rst_n    = rst;
    digits   = dig;
    dp_mask  = dpm;
    en_mask  = enm;
    blank_lz = lz;
    e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1};
    if (!rst) begin
      model_t = 0;
    end else begin
      pos       = model_t % RDIV;
      slot      = (model_t / RDIV) % 8;
      lead_zero = (slot > 0) && ((dig >> (4 * slot)) == 32'd0);
      if (pos >= BLANK && enm[slot] && !(lz && lead_zero)) begin
        e.an       = ~(8'd1 << slot);
        e.seg      = SEG_TBL[(dig >> (4 * slot)) & 32'hF];
        e.dp       = ~dpm[slot];
      end
      model_t++;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic runCycles(input int n, input logic [31:0] dig, input logic [7:0] dpm,
                           input logic [7:0] enm, input logic lz);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, dig, dpm, enm, lz);
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 8'h00, 8'hFF, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    checks++;
    if ($countones(~AN) > 1) begin
      failures++;
      $display("[TB] FAIL onehot_an at %0t: got %b expected at most one low bit", $time, AN);
    end
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty at %0t: got no entry expected one", $time);
    end else begin
      e = sb_q.pop_front();
      checkOutput("AN", AN, e.an);
      checkOutput("SEG", {1'b0, CA, CB, CC, CD, CE, CF, CG}, {1'b0, e.seg});
      checkOutput("DP", {7'b0, DP}, {7'b0, e.dp});
    end
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  rdp, ren;
    logic        rlz;
    int          drain;

    doReset(3);
    $display("[TB] scan of 7654_3210");
    runCycles(2 * 8 * RDIV, 32'h7654_3210, 8'h00, 8'hFF, 1'b0);
    $display("[TB] scan of FEDC_BA98");
    runCycles(8 * RDIV, 32'hFEDC_BA98, 8'h00, 8'hFF, 1'b0);
    $display("[TB] leading-zero blanking");
    runCycles(8 * RDIV, 32'h0000_0305, 8'h00, 8'hFF, 1'b1);
    runCycles(8 * RDIV, 32'h0000_0305, 8'h00, 8'hFF, 1'b0);
    runCycles(8 * RDIV, 32'h0000_0000, 8'hFF, 8'hFF, 1'b1);
    $display("[TB] sparse enable mask");
    runCycles(8 * RDIV, 32'h7654_3210, 8'h5A, 8'b1010_0101, 1'b0);

    $display("[TB] reset mid-slot 5");
    doReset(1);
    runCycles(5 * RDIV + 2, 32'h7654_3210, 8'h00, 8'hFF, 1'b0);
    doReset(1);
    runCycles(3 * 8 * RDIV, 32'h7654_3210, 8'h00, 8'hFF, 1'b0);

    $display("[TB] randomized traffic");
    rd = $urandom; rdp = 8'($urandom); ren = 8'($urandom); rlz = 1'($urandom);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        rd  = $urandom & (32'hFFFF_FFFF >> (4 * $urandom_range(0, 7)));
        rdp = 8'($urandom);
        ren = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
        rlz = 1'($urandom);
      end
      if ($urandom_range(0, 99) == 0) applyStimulus(1'b0, rd, rdp, ren, rlz);
      else                            applyStimulus(1'b1, rd, rdp, ren, rlz);
    end

    drain = 0;
    while (sb_q.size() != 0 && drain < 4) begin
      @(negedge clk);
      #1;
      drain++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
